// File: rtl/vram_line_writer.sv
// Packs a WORD_W-bit pixel stream into LINE_W-bit lines and writes each line to VRAM port A.
// Define VRAM_CLEAR_EN to add the clear_req port and the full-frame CLEAR sequence.
module vram_line_writer #(
    parameter int unsigned LINE_W    = 640,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned NUM_LINES = 480
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_sof,
`ifdef VRAM_CLEAR_EN
    input  logic              clear_req,
`endif
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [LINE_W-1:0] vram_din,
    output logic              line_done,
    output logic              frame_done
);
    localparam int unsigned WPL   = LINE_W / WORD_W;
    localparam int unsigned CNT_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WPL - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);

`ifdef VRAM_CLEAR_EN
    typedef enum logic [1:0] {FILL, COMMIT, CLEAR} state_e;
`else
    typedef enum logic {FILL, COMMIT} state_e;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] din_q, din_d;
    logic              ld_q, ld_d;
    logic              fd_q, fd_d;
    logic              accept_c;
`ifdef VRAM_CLEAR_EN
    logic              clear_go_c;
`endif

    // Ready only in FILL; a pending clear at a line boundary steals the cycle
    always_comb begin
`ifdef VRAM_CLEAR_EN
        clear_go_c = (state_q == FILL) && (word_cnt_q == '0) && clear_req;
        s_ready    = clr_n && (state_q == FILL) && !clear_go_c;
`else
        s_ready    = clr_n && (state_q == FILL);
`endif
        accept_c   = s_valid && s_ready;
    end

    // Next-state and registered-output logic; outputs are loaded one edge early
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        line_buf_d = line_buf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        ld_d       = 1'b0;
        fd_d       = 1'b0;
        unique case (state_q)
            FILL: begin
`ifdef VRAM_CLEAR_EN
                if (clear_go_c) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = '0;
                    fd_d    = (LAST_LINE == '0);
                end else
`endif
                if (accept_c) begin
                    if (s_sof) begin
                        // New frame: this word restarts line 0, partial line dropped
                        line_cnt_d             = '0;
                        line_buf_d[WORD_W-1:0] = s_data;
                        word_cnt_d             = CNT_W'(1);
                    end else begin
                        line_buf_d[word_cnt_q*WORD_W +: WORD_W] = s_data;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = COMMIT;
                            we_d       = 1'b1;
                            addr_d     = line_cnt_q;
                            din_d      = line_buf_d;
                            ld_d       = 1'b1;
                            fd_d       = (line_cnt_q == LAST_LINE);
                        end else begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            COMMIT: begin
                state_d    = FILL;
                line_cnt_d = (line_cnt_q == LAST_LINE) ? '0 : line_cnt_q + ADDR_W'(1);
            end
`ifdef VRAM_CLEAR_EN
            CLEAR: begin
                if (addr_q == LAST_LINE) begin
                    state_d    = FILL;
                    line_cnt_d = '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    fd_d   = ((addr_q + ADDR_W'(1)) == LAST_LINE);
                end
            end
`endif
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= FILL;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            line_buf_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            ld_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            line_buf_q <= line_buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            ld_q       <= ld_d;
            fd_q       <= fd_d;
        end
    end

    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_din   = din_q;
    assign line_done  = ld_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_vram_line_writer.sv
// Directed bench for vram_line_writer: a reference line packer feeds a scoreboard of
// expected VRAM writes that a negedge monitor pops and compares.
module tb_vram_line_writer;
    localparam int unsigned LINE_W = 640;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned NLINES = 480;
    localparam int unsigned WPL    = LINE_W / WORD_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] din;
        logic              ld;
        logic              fd;
    } exp_t;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_sof;
    logic              clear_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [LINE_W-1:0] vram_din;
    logic              line_done;
    logic              frame_done;

    vram_line_writer #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_LINES(NLINES)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
`ifdef VRAM_CLEAR_EN
        .clear_req (clear_req),
`endif
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .line_done (line_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          fd_cnt = 0;
    bit          started = 1'b0;
    exp_t        sb[$];
    logic [WORD_W-1:0] mbuf [WPL];
    int          mwc = 0;
    int          mlc = 0;

    task automatic chk(input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: observed no progress, expected DUT event", tag);
        finish_sim();
    endtask

    // Reference packer: word k of a line lands at bits [k*32 +: 32]
    task automatic model_accept(input logic [WORD_W-1:0] d, input bit sof);
        logic [LINE_W-1:0] line;
        if (sof) begin
            mwc = 0;
            mlc = 0;
        end
        mbuf[mwc] = d;
        mwc++;
        if (mwc == WPL) begin
            for (int k = 0; k < WPL; k++) line[k*WORD_W +: WORD_W] = mbuf[k];
            sb.push_back('{addr: ADDR_W'(mlc), din: line, ld: 1'b1, fd: (mlc == NLINES - 1)});
            mlc = (mlc == NLINES - 1) ? 0 : mlc + 1;
            mwc = 0;
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input bit sof);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(negedge clk);
        while (s_ready !== 1'b1) begin
            guard++;
            if (guard > 1000) timeout("send_ready");
            @(negedge clk);
        end
        @(posedge clk);
        model_accept(d, sof);
        #1;
        s_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int g = 0;
        s_valid = 1'b0;
        while (sb.size() != 0 && g < bound) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) timeout("drain");
        idle(2);
    endtask

    task automatic push_clear();
        for (int i = 0; i < NLINES; i++)
            sb.push_back('{addr: ADDR_W'(i), din: '0, ld: 1'b0, fd: (i == NLINES - 1)});
        mlc = 0;
    endtask

    // Monitor: every write must match the scoreboard head; pulses only with writes
    always @(negedge clk) begin
        exp_t e;
        if (started && clr_n === 1'b1) begin
            if (frame_done === 1'b1) fd_cnt++;
            if (vram_we === 1'b1) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_write: observed addr %0d, expected no write", vram_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk(LINE_W'(vram_addr), LINE_W'(e.addr), "wr_addr");
                    chk(vram_din, e.din, "wr_din");
                    chk(LINE_W'(line_done), LINE_W'(e.ld), "wr_line_done");
                    chk(LINE_W'(frame_done), LINE_W'(e.fd), "wr_frame_done");
                end
            end else begin
                chk(LINE_W'(line_done), '0, "idle_line_done");
                chk(LINE_W'(frame_done), '0, "idle_frame_done");
            end
            if (clear_req === 1'b0) chk(LINE_W'(s_ready), LINE_W'(!vram_we), "s_ready_vs_commit");
        end
    end

    initial begin
        int cycles;
        int g;
        clr_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; clear_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(LINE_W'(vram_we), '0, "rst_we");
        chk(LINE_W'(vram_addr), '0, "rst_addr");
        chk(vram_din, '0, "rst_din");
        chk(LINE_W'(line_done), '0, "rst_line_done");
        chk(LINE_W'(frame_done), '0, "rst_frame_done");
        chk(LINE_W'(s_ready), '0, "rst_s_ready");
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk(LINE_W'(s_ready), LINE_W'(1), "ready_after_rst");
        started = 1'b1;
        @(posedge clk);
        #1;

        // First line, back-to-back, and its one-cycle commit latency
        for (int k = 0; k < WPL; k++) send_word(WORD_W'(k + 1), k == 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk(LINE_W'(vram_we), LINE_W'(1), "t1_we_latency");
        chk(LINE_W'(vram_addr), '0, "t1_addr");
        chk(LINE_W'(vram_din[31:0]), LINE_W'(1), "t1_din_word0");
        chk(LINE_W'(vram_din[639:608]), LINE_W'(32'h14), "t1_din_word19");
        chk(LINE_W'(line_done), LINE_W'(1), "t1_line_done");
        @(negedge clk);
        chk(LINE_W'(vram_we), '0, "t1_we_single");
        drain(50);

        // Full frame plus one line: addresses wrap, frame_done only at the last line
        fd_cnt = 0;
        for (int l = 0; l < NLINES + 1; l++)
            for (int k = 0; k < WPL; k++) send_word($urandom, (l == 0) && (k == 0));
        drain(50);
        chk(LINE_W'(fd_cnt), LINE_W'(1), "t2_frame_done_count");
        chk(LINE_W'(mlc), LINE_W'(1), "t2_model_line_cnt");

        // Mid-line start of frame discards the partial line 3
        for (int k = 0; k < 2 * WPL + 7; k++) send_word($urandom, 1'b0);
        send_word(32'hCAFE_0003, 1'b1);
        for (int k = 1; k < WPL; k++) send_word($urandom, 1'b0);
        drain(50);

        // Random source gaps, with valid often held high across COMMIT
        for (int l = 0; l < 6; l++)
            for (int k = 0; k < WPL; k++) begin
                send_word($urandom, 1'b0);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        drain(50);

        // Async reset mid-line
        for (int k = 0; k < 10; k++) send_word($urandom, 1'b0);
        s_valid = 1'b0;
        clr_n = 1'b0;
        #1;
        chk(LINE_W'(vram_we), '0, "t5_we");
        chk(LINE_W'(vram_addr), '0, "t5_addr");
        chk(vram_din, '0, "t5_din");
        chk(LINE_W'(line_done), '0, "t5_line_done");
        chk(LINE_W'(frame_done), '0, "t5_frame_done");
        chk(LINE_W'(s_ready), '0, "t5_s_ready");
        mwc = 0; mlc = 0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < WPL; k++) send_word($urandom, 1'b0);
        drain(50);

        // Async reset during the commit cycle drops the write at once
        for (int k = 0; k < WPL; k++) send_word($urandom, 1'b0);
        s_valid = 1'b0;
        clr_n = 1'b0;
        #1;
        chk(LINE_W'(vram_we), '0, "t5_commit_we");
        void'(sb.pop_back());
        mwc = 0; mlc = 0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < WPL; k++) send_word($urandom, 1'b0);
        drain(50);

`ifdef VRAM_CLEAR_EN
        // Clear at a line boundary: NUM_LINES consecutive zero writes
        fd_cnt = 0;
        clear_req = 1'b1;
        push_clear();
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        cycles = 0;
        @(negedge clk);
        while (vram_we === 1'b1 && cycles < 1000) begin
            cycles++;
            @(negedge clk);
        end
        chk(LINE_W'(cycles), LINE_W'(NLINES), "t6_clear_len");
        chk(LINE_W'(s_ready), LINE_W'(1), "t6_ready_after_clear");
        chk(LINE_W'(fd_cnt), LINE_W'(1), "t6_frame_done_count");
        drain(50);

        // Clear requested mid-line waits for that line's commit
        for (int k = 0; k < 5; k++) send_word($urandom, 1'b0);
        clear_req = 1'b1;
        for (int k = 5; k < WPL; k++) send_word($urandom, 1'b0);
        s_valid = 1'b0;
        push_clear();
        g = 0;
        @(negedge clk);
        while (!(vram_we === 1'b1 && line_done === 1'b0) && g < 50) begin
            g++;
            @(negedge clk);
        end
        if (g >= 50) timeout("clear_start");
        clear_req = 1'b0;
        drain(600);
`endif

        chk(LINE_W'(sb.size()), '0, "scoreboard_empty");
        finish_sim();
    end

endmodule
